asym_fifo_write_wider: RTL and testbench
========================================

ASYM_FIFO_WRITE_WIDER -- requirements
Module: asym_fifo_write_wider

Interface
REQ-001 SHALL provide parameter DATAWIDTHA, default 128, wide write-port width in bits.
REQ-002 SHALL provide parameter DATAWIDTHB, default 32, narrow read-port width in bits; DATAWIDTHA/DATAWIDTHB SHALL be a power of two >= 2 (RATIO).
REQ-003 SHALL provide parameter SIZEA, default 16, storage depth in wide words (power of two).
REQ-004 SHALL provide parameter ADDRWIDTHA, default 4, log2(SIZEA).
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear  input  1  synchronous flush.
REQ-008 SHALL have port weA  input  1  wide-word write request.
REQ-009 SHALL have port diA  input  DATAWIDTHA  wide write data.
REQ-010 SHALL have port full  output  1  storage holds SIZEA wide words.
REQ-011 SHALL have port level  output  ADDRWIDTHA+1  wide words resident in storage.
REQ-012 SHALL have port doB  output  DATAWIDTHB  narrow read data, registered.
REQ-013 SHALL have port validB  output  1  doB holds a valid slice, registered.
REQ-014 SHALL have port readyB  input  1  consumer accepts doB.
REQ-015 SHALL have port overflow  output  1  sticky: write dropped.

Function
REQ-016 SHALL accept a write at an edge where weA=1, full=0 and clear=0, and store diA at the write pointer, then increment the pointer modulo SIZEA.
REQ-017 SHALL drop a write with weA=1 while full=1 (evaluated on the registered full value, even if a word is freed the same cycle), and SHALL set overflow=1.
REQ-018 SHALL emit each wide word as RATIO narrow slices, in order slice 0 first, where slice i = diA bits [(i+1)*DATAWIDTHB-1 : i*DATAWIDTHB].
REQ-019 SHALL emit words in write order (FIFO), wrapping the read pointer modulo SIZEA.
REQ-020 SHALL load the output register with the next slice at an edge where storage is non-empty and (validB=0 or readyB=1); otherwise doB and validB SHALL hold.
REQ-021 SHALL set validB=0 at an edge where validB=1, readyB=1 and no slice is available to load.
REQ-022 SHALL ignore readyB while validB=0.
REQ-023 SHALL free a wide word (decrement level, advance read pointer, reset slice index to 0) at the edge that loads its last slice (RATIO-1) into the output register.
REQ-024 SHALL keep level unchanged at an edge with both an accepted write and a freed word.
REQ-025 SHALL drive full=1 exactly when level==SIZEA; full and level SHALL be registered.
REQ-026 SHALL achieve latency: write accepted at edge k into empty storage with validB=0 -> validB=1 and doB=slice 0 after edge k+1.
REQ-027 SHALL sustain one slice per clock with readyB held high and storage non-empty, with no bubble between slices or between consecutive words.
REQ-028 SHALL, on clear=1, set pointers, slice index, level, validB and overflow to 0, and discard any same-cycle write; doB is don't-care.
REQ-029 SHALL NOT require storage contents to be initialised; unread locations are never presented on doB.

Reset
REQ-030 SHALL, while rst=1 (asynchronous assertion), force validB=0, doB=0, full=0, level=0, overflow=0, and reset pointers and slice index to 0.
REQ-031 SHALL discard all stored data on reset mid-operation; the first slice after rst deasserts SHALL come from the first word written afterwards.

Verification
REQ-032 SHALL verify single word: write 0x44444444_33333333_22222222_11111111, readyB=1 -> doB 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles starting one edge after the write, then validB=0.
REQ-033 SHALL verify fill/overflow: 17 writes with readyB=0 -> full=1 and level=16 after the 16th write, 17th write dropped, overflow=1; drain yields 64 slices of words 0..15 only.
REQ-034 SHALL verify backpressure: toggle readyB pseudo-randomly during 8 words -> doB stable while validB=1 and readyB=0; all 32 slices in order, none duplicated.
REQ-035 SHALL verify wrap and concurrency: stream 40 words with one write per 4 cycles and readyB=1 -> level never exceeds 2, full never 1, data in order across pointer wrap.
REQ-036 SHALL verify full with simultaneous free: level=16, weA=1 on the cycle the last slice of word 0 loads -> write dropped, overflow=1, level=15 next cycle.
REQ-037 SHALL verify clear/reset mid-stream: assert clear (then separately rst) during slice 2 of a word -> validB=0, level=0, overflow=0 next cycle; the next write reads back from slice 0.

Source files
------------

// File: rtl/asym_fifo_write_wider.sv
// Purpose : width-converting FIFO; wide words written on port A, emitted as narrow
//           slices (slice 0 = least significant) on a registered valid/ready port B.
// Latency : word written at edge k into an empty FIFO appears as slice 0 after edge k+1.
// Backpr. : doB/validB hold while readyB=0; writes while full are dropped and flag overflow.
//
// Ports:
//   clk, rst        single rising-edge clock, asynchronous active-high reset
//   clear           synchronous flush (pointers, level, output valid, overflow)
//   weA, diA        wide-word write request and data
//   full, level     registered occupancy in wide words (full when level == SIZEA)
//   doB, validB     registered narrow output slice and its valid flag
//   readyB          consumer accepts doB (ignored while validB=0)
//   overflow        sticky flag: a write was dropped because the FIFO was full
module asym_fifo_write_wider #(
    parameter int DATAWIDTHA = 128,
    parameter int DATAWIDTHB = 32,
    parameter int SIZEA      = 16,
    parameter int ADDRWIDTHA = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  weA,
    input  logic [DATAWIDTHA-1:0] diA,
    output logic                  full,
    output logic [ADDRWIDTHA:0]   level,
    output logic [DATAWIDTHB-1:0] doB,
    output logic                  validB,
    input  logic                  readyB,
    output logic                  overflow
);

    localparam int RATIO = DATAWIDTHA / DATAWIDTHB;
    localparam int SLW   = $clog2(RATIO);

    localparam logic [ADDRWIDTHA:0]   LVL_ONE  = 1;
    localparam logic [ADDRWIDTHA:0]   LVL_FULL = (ADDRWIDTHA + 1)'(SIZEA);
    localparam logic [ADDRWIDTHA-1:0] PTR_ONE  = 1;
    localparam logic [SLW-1:0]        SL_ONE   = 1;
    localparam logic [SLW-1:0]        SL_LAST  = SLW'(RATIO - 1);

    // Storage is deliberately not reset; only locations that were written and
    // are still counted in level are ever read.
    logic [DATAWIDTHA-1:0] mem [SIZEA];

    logic [ADDRWIDTHA-1:0] wr_ptr;
    logic [ADDRWIDTHA-1:0] rd_ptr;
    logic [SLW-1:0]        slice_idx;

    logic                  wr_acc;
    logic                  nonempty;
    logic                  load;
    logic                  free_word;
    logic [ADDRWIDTHA:0]   level_nxt;
    logic [DATAWIDTHA-1:0] rd_word;
    logic [DATAWIDTHB-1:0] slice_dat;

    // Acceptance uses the registered full flag, so a word freed on the same
    // edge does not make room for a write yet.
    assign wr_acc    = weA & ~full & ~clear;
    assign nonempty  = (level != '0);
    assign load      = nonempty & (~validB | readyB);
    assign free_word = load & (slice_idx == SL_LAST);
    assign rd_word   = mem[rd_ptr];

    always_comb begin
        slice_dat = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (slice_idx == SLW'(i)) begin
                slice_dat = rd_word[i*DATAWIDTHB +: DATAWIDTHB];
            end
        end
    end

    // Simultaneous accept and free cancel out.
    always_comb begin
        level_nxt = level;
        if (wr_acc && !free_word) begin
            level_nxt = level + LVL_ONE;
        end else if (!wr_acc && free_word) begin
            level_nxt = level - LVL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= diA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            slice_idx <= '0;
            level     <= '0;
            full      <= 1'b0;
            doB       <= '0;
            validB    <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear) begin
            // doB is left as-is; it is meaningless while validB=0.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            slice_idx <= '0;
            level     <= '0;
            full      <= 1'b0;
            validB    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (weA && full) begin
                overflow <= 1'b1;
            end

            if (load) begin
                doB    <= slice_dat;
                validB <= 1'b1;
                if (free_word) begin
                    slice_idx <= '0;
                    rd_ptr    <= rd_ptr + PTR_ONE;
                end else begin
                    slice_idx <= slice_idx + SL_ONE;
                end
            end else if (validB && readyB) begin
                validB <= 1'b0;
            end

            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
        end
    end

endmodule

// File: tb/tb_asym_fifo_write_wider.sv
module tb_asym_fifo_write_wider;

    localparam int DA = 128;
    localparam int DB = 32;
    localparam int SZ = 16;
    localparam int AW = 4;
    localparam int R  = DA / DB;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          weA;
    logic [DA-1:0] diA;
    logic          full;
    logic [AW:0]   level;
    logic [DB-1:0] doB;
    logic          validB;
    logic          readyB;
    logic          overflow;

    asym_fifo_write_wider #(
        .DATAWIDTHA(DA),
        .DATAWIDTHB(DB),
        .SIZEA(SZ),
        .ADDRWIDTHA(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .weA(weA),
        .diA(diA),
        .full(full),
        .level(level),
        .doB(doB),
        .validB(validB),
        .readyB(readyB),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue of whole words still in storage, count of slices
    // already taken from the head word, and the output register contents.
    logic [DA-1:0] m_store[$];
    int            m_head;
    logic          m_vld;
    logic [DB-1:0] m_dat;
    logic          m_ovf;
    int            max_level;
    int            full_seen;

    task automatic chk(input string tag, input logic [DA-1:0] obs, input logic [DA-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_store.delete();
        m_head = 0;
        m_vld  = 1'b0;
        m_dat  = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_edge();
        bit            full_pre;
        logic [DA-1:0] w;
        if (clear) begin
            m_store.delete();
            m_head = 0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        full_pre = (m_store.size() == SZ);
        if (m_store.size() > 0 && (!m_vld || readyB)) begin
            w      = m_store[0];
            m_dat  = w[m_head*DB +: DB];
            m_vld  = 1'b1;
            m_head = m_head + 1;
            if (m_head == R) begin
                void'(m_store.pop_front());
                m_head = 0;
            end
        end else if (m_vld && readyB) begin
            m_vld = 1'b0;
        end
        if (weA) begin
            if (full_pre) m_ovf = 1'b1;
            else          m_store.push_back(diA);
        end
    endtask

    task automatic check_outputs();
        chk("validB", validB, m_vld);
        if (m_vld) chk("doB", doB, m_dat);
        chk("level", level, m_store.size());
        chk("full", full, m_store.size() == SZ);
        chk("overflow", overflow, m_ovf);
        if (int'(level) > max_level) max_level = int'(level);
        if (full) full_seen++;
    endtask

    // Inputs are set at the falling edge before calling; outputs are checked
    // at the following falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_validB", validB, 0);
        chk("rst_doB", doB, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic drain();
        bit done;
        weA    = 1'b0;
        readyB = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_store.size() == 0 && !m_vld) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        chk("drain_done", done, 1);
    endtask

    function automatic logic [DA-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DA-1:0] w;
        logic [DB-1:0] exp_s [4];
        bit            done;
        int            written;

        rst = 1'b1; clear = 1'b0; weA = 1'b0; diA = '0; readyB = 1'b0;
        max_level = 0; full_seen = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single word, explicit slice sequence.
        exp_s[0] = 32'h11111111; exp_s[1] = 32'h22222222;
        exp_s[2] = 32'h33333333; exp_s[3] = 32'h44444444;
        readyB = 1'b1; weA = 1'b1;
        diA = 128'h44444444_33333333_22222222_11111111;
        cycle();
        weA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("single_vld", validB, 1);
            chk("single_doB", doB, exp_s[i]);
        end
        cycle();
        chk("single_end_vld", validB, 0);

        // Fill with consumer stalled, 17th write dropped.
        readyB = 1'b0;
        for (int i = 0; i < 17; i++) begin
            weA = 1'b1; diA = rnd_word();
            cycle();
            if (i == 15) begin
                chk("fill_level16", level, 16);
                chk("fill_full", full, 1);
                chk("fill_ovf_before", overflow, 0);
            end
        end
        weA = 1'b0;
        chk("fill_ovf", overflow, 1);
        drain();

        // Random backpressure over 8 words.
        do_clear();
        written = 0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            weA    = (written < 8) && ($urandom_range(0, 1) == 1);
            diA    = rnd_word();
            readyB = ($urandom_range(0, 1) == 1);
            if (weA) written++;
            cycle();
            if (written == 8 && m_store.size() == 0 && !m_vld) begin
                done = 1'b1;
                break;
            end
        end
        chk("bp_done", done, 1);
        chk("bp_no_ovf", overflow, 0);

        // Streaming 40 words, one write every 4 cycles, across pointer wrap.
        max_level = 0; full_seen = 0;
        readyB = 1'b1;
        for (int i = 0; i < 40; i++) begin
            weA = 1'b1; diA = rnd_word();
            cycle();
            weA = 1'b0;
            for (int k = 0; k < 3; k++) cycle();
        end
        drain();
        chk("wrap_maxlevel_le2", max_level <= 2, 1);
        chk("wrap_never_full", full_seen, 0);

        // Full with a simultaneous free: write still dropped.
        do_clear();
        readyB = 1'b0;
        for (int i = 0; i < 16; i++) begin
            weA = 1'b1; diA = rnd_word();
            cycle();
        end
        weA = 1'b0;
        readyB = 1'b1;
        for (int i = 0; i < 8 && m_head != R - 1; i++) cycle();
        weA = 1'b1; diA = rnd_word();
        cycle();
        weA = 1'b0;
        chk("fullfree_ovf", overflow, 1);
        chk("fullfree_level15", level, 15);
        drain();

        // Clear during slice 2, with a same-cycle write that must be discarded.
        do_clear();
        readyB = 1'b1; weA = 1'b1; diA = rnd_word();
        cycle();
        weA = 1'b0;
        for (int i = 0; i < 8 && m_head != 3; i++) cycle();
        clear = 1'b1; weA = 1'b1; diA = rnd_word();
        cycle();
        clear = 1'b0; weA = 1'b0;
        chk("clr_vld", validB, 0);
        chk("clr_level", level, 0);
        chk("clr_ovf", overflow, 0);
        w = rnd_word(); weA = 1'b1; diA = w;
        cycle();
        weA = 1'b0;
        cycle();
        chk("clr_next_doB", doB, w[DB-1:0]);
        drain();

        // Asynchronous reset during slice 2.
        weA = 1'b1; diA = rnd_word();
        cycle();
        weA = 1'b0;
        for (int i = 0; i < 8 && m_head != 3; i++) cycle();
        do_reset();
        w = rnd_word(); weA = 1'b1; diA = w;
        cycle();
        weA = 1'b0;
        cycle();
        chk("rst_next_doB", doB, w[DB-1:0]);
        drain();

        // Random soak with occasional clears.
        for (int c = 0; c < 600; c++) begin
            weA    = ($urandom_range(0, 2) != 0);
            diA    = rnd_word();
            readyB = ($urandom_range(0, 3) != 0);
            clear  = ($urandom_range(0, 99) == 0);
            cycle();
        end
        clear = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
